// File: rtl/truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_checker
// Function : Drives all 16 vectors of a 4-input function into a DUT, captures
//            its response and compares it against an expected truth table.
// Revision : 1.0
// ============================================================================
module truth_table_checker #(
    parameter logic [15:0] EXPECTED = 16'h0000,
    parameter int unsigned HOLD     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        dut_out,
    output logic        first_in,
    output logic        second_in,
    output logic        third_in,
    output logic        fourth_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] capture,
    output logic [15:0] mismatch,
    output logic [4:0]  err_count
);

    localparam logic [7:0] c_HOLD_LAST = 8'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_vec;
    logic [7:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_capture;
    logic [15:0] r_mismatch;
    logic [4:0]  r_err;
    logic        w_miss_bit;

    assign w_miss_bit = dut_out ^ EXPECTED[r_vec];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_vec      <= 4'd0;
            r_cnt      <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_capture  <= 16'd0;
            r_mismatch <= 16'd0;
            r_err      <= 5'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_RUN;
                        r_vec      <= 4'd0;
                        r_cnt      <= 8'd0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_capture  <= 16'd0;
                        r_mismatch <= 16'd0;
                        r_err      <= 5'd0;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        r_capture[r_vec]  <= dut_out;
                        r_mismatch[r_vec] <= w_miss_bit;
                        r_err             <= r_err + {4'd0, w_miss_bit};
                        r_cnt             <= 8'd0;
                        // Last vector ends the run instead of wrapping the counter
                        if (r_vec == 4'd15) begin
                            r_state <= ST_DONE;
                            r_vec   <= 4'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_vec <= r_vec + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_vec   <= 4'd0;
                    r_cnt   <= 8'd0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign first_in  = r_vec[3];
    assign second_in = r_vec[2];
    assign third_in  = r_vec[1];
    assign fourth_in = r_vec[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign capture   = r_capture;
    assign mismatch  = r_mismatch;
    assign err_count = r_err;
    assign pass      = r_done && (r_mismatch == 16'd0);

endmodule
`default_nettype wire
